// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard front-end: synchronised frame receiver feeding a scancode FIFO
// with a sticky overflow flag and a CPU interrupt (pulse-stretch or level mode).
module ps2_key_fifo #(
    parameter int DEPTH      = 8,
    parameter int INT_MODE   = 0,
    parameter int INT_CYCLES = 13,
    parameter int TIMEOUT    = 16384
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         ps2_clk,
    input  logic                         ps2_data,
    input  logic                         rd,
    input  logic                         ovf_clr,
    output logic [7:0]                   datao,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         error,
    output logic                         interrupt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [7:0]       INT_LOAD = 8'(INT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic [2:0]       clk_sync_r;
    logic [1:0]       data_sync_r;
    logic             bit_evt_s;
    logic             bit_s;
    state_t           state_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             par_r;
    logic [TMR_W-1:0] timer_r;
    logic             push_r;
    logic [7:0]       push_data_r;
    logic             error_r;

    logic [7:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic             full_s, pop_s, push_acc_s, drop_s;
    logic [7:0]       head_nxt_s, datao_r, int_cnt_r, int_cnt_nxt_s;
    logic             empty_r, ovf_r, interrupt_r, int_nxt_s;

    // Pin synchronisers; clk_sync_r[2] is the previous synchronised ps2_clk for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_r  <= 3'b000;
            data_sync_r <= 2'b00;
        end else begin
            clk_sync_r  <= {clk_sync_r[1:0], ps2_clk};
            data_sync_r <= {data_sync_r[0], ps2_data};
        end
    end

    assign bit_evt_s = clk_sync_r[2] & ~clk_sync_r[1];
    assign bit_s     = data_sync_r[1];

    // Frame receiver with inter-edge timeout; push_r/error_r are single-cycle strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            par_r       <= 1'b0;
            timer_r     <= '0;
            push_r      <= 1'b0;
            push_data_r <= 8'h00;
            error_r     <= 1'b0;
        end else begin
            push_r  <= 1'b0;
            error_r <= 1'b0;
            if (bit_evt_s) begin
                timer_r <= '0;
                case (state_r)
                    ST_IDLE: begin
                        if (!bit_s) begin
                            state_r   <= ST_DATA;
                            bit_cnt_r <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shift_r   <= {bit_s, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_r   <= bit_s;
                        state_r <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (bit_s && odd_parity_ok(shift_r, par_r)) begin
                            push_r      <= 1'b1;
                            push_data_r <= shift_r;
                        end else begin
                            error_r <= 1'b1;
                        end
                        state_r <= ST_IDLE;
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end else if (state_r != ST_IDLE) begin
                if (timer_r == TMR_LAST) begin
                    error_r <= 1'b1;
                    state_r <= ST_IDLE;
                    timer_r <= '0;
                end else begin
                    timer_r <= timer_r + TMR_W'(1);
                end
            end else begin
                timer_r <= '0;
            end
        end
    end

    // Next-state FIFO bookkeeping, head byte and interrupt level
    always_comb begin
        full_s       = (count_r == FULL_CNT);
        pop_s        = rd && (count_r != '0);
        push_acc_s   = push_r && (!full_s || pop_s);
        drop_s       = push_r && full_s && !pop_s;
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        case ({push_acc_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
        // The incoming byte becomes the head when it lands in the slot the read pointer moves to
        if (count_nxt_s == '0) begin
            head_nxt_s = 8'h00;
        end else if (push_acc_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_nxt_s = push_data_r;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
        if (push_acc_s) begin
            int_cnt_nxt_s = INT_LOAD;
        end else if (int_cnt_r != 8'd0) begin
            int_cnt_nxt_s = int_cnt_r - 8'd1;
        end else begin
            int_cnt_nxt_s = int_cnt_r;
        end
        if (INT_MODE == 0) begin
            int_nxt_s = (int_cnt_nxt_s != 8'd0);
        end else begin
            int_nxt_s = (count_nxt_s != '0);
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_acc_s) begin
            mem_r[wr_ptr_r] <= push_data_r;
        end
    end

    // FIFO pointers, registered status outputs and interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            empty_r     <= 1'b1;
            datao_r     <= 8'h00;
            ovf_r       <= 1'b0;
            int_cnt_r   <= 8'd0;
            interrupt_r <= 1'b0;
        end else begin
            if (push_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            empty_r     <= (count_nxt_s == '0);
            datao_r     <= head_nxt_s;
            int_cnt_r   <= int_cnt_nxt_s;
            interrupt_r <= int_nxt_s;
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign datao     = datao_r;
    assign empty     = empty_r;
    assign count     = count_r;
    assign overflow  = ovf_r;
    assign error     = error_r;
    assign interrupt = interrupt_r;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Randomised scoreboard bench for ps2_key_fifo: a byte queue models the FIFO,
// monitors compare read data and error pulses against expectations from the driver.
module tb_ps2_key_fifo;
    localparam int DEPTH      = 8;
    localparam int INT_CYCLES = 13;
    localparam int TIMEOUT    = 1000;
    localparam int HALF       = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] datao;
    logic       empty;
    logic [3:0] count;
    logic       overflow, error, interrupt;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] ref_q[$];
    bit         ref_ovf = 1'b0;
    int         err_exp = 0;
    int         int_hi = 0;

    always #5 clk = ~clk;

    ps2_key_fifo #(
        .DEPTH(DEPTH), .INT_MODE(0), .INT_CYCLES(INT_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd(rd), .ovf_clr(ovf_clr), .datao(datao), .empty(empty), .count(count),
        .overflow(overflow), .error(error), .interrupt(interrupt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: error pulses, interrupt high time and popped bytes against the model
    always @(negedge clk) begin
        if (interrupt) int_hi++;
        if (reset_n && error) begin
            check("error_pulse_expected", 32'(err_exp > 0), 32'd1);
            if (err_exp > 0) err_exp--;
        end
        if (reset_n && rd) begin
            if (!empty) begin
                check("model_nonempty_on_read", 32'(ref_q.size() != 0), 32'd1);
                if (ref_q.size() != 0) begin
                    check("read_data", 32'(datao), 32'(ref_q[0]));
                    void'(ref_q.pop_front());
                end
            end else begin
                check("model_empty_on_read", 32'(ref_q.size()), 32'd0);
                check("datao_zero_when_empty", 32'(datao), 32'd0);
            end
        end
    end

    task automatic ps2_bit(input logic v, input bit rd_at_push);
        @(posedge clk); #1 ps2_data = v;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        if (rd_at_push) begin
            // falling edge reaches the FSM after 3 edges; the next cycle is the push cycle
            repeat (3) @(posedge clk);
            #1 rd = 1'b1;
            @(posedge clk);
            #1 rd = 1'b0;
            repeat (HALF - 4) @(posedge clk);
        end else begin
            repeat (HALF) @(posedge clk);
        end
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit rd_push);
        logic [10:0] bits;
        bits = {1'b1 ^ bad_stop, ~(^b) ^ bad_par, b, 1'b0};
        if (bad_par || bad_stop) err_exp++;
        for (int i = 0; i < 11; i++) ps2_bit(bits[i], rd_push && (i == 10));
        repeat (4) @(posedge clk);
        #1;
        if (!bad_par && !bad_stop) begin
            if (ref_q.size() < DEPTH || rd_push) ref_q.push_back(b);
            else ref_ovf = 1'b1;
        end
    endtask

    task automatic read_n(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1 rd = 1'b1;
            @(posedge clk); #1 rd = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_ovf();
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        ref_ovf = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'(ref_q.size()));
        check({tag, "_empty"}, 32'(empty), 32'(ref_q.size() == 0));
        check({tag, "_overflow"}, 32'(overflow), 32'(ref_ovf));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        #23;
        check("rst_datao", 32'(datao), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_interrupt", 32'(interrupt), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // single good frame and interrupt stretch
        int_hi = 0;
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        repeat (30) @(posedge clk); #1;
        check_state("t1");
        check("t1_datao", 32'(datao), 32'h1C);
        check("t1_int_cycles", 32'(int_hi), 32'(INT_CYCLES));
        read_n(1);
        check_state("t1_drained");

        // parity error: no push, no interrupt
        int_hi = 0;
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        repeat (30) @(posedge clk); #1;
        check_state("t2");
        check("t2_int_cycles", 32'(int_hi), 32'd0);

        // overflow with DEPTH+1 frames
        for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        check("t3_count", 32'(count), 32'd8);
        check("t3_overflow", 32'(overflow), 32'd1);
        check_state("t3");
        read_n(DEPTH);
        check("t3_empty_after", 32'(empty), 32'd1);
        check("t3_datao_after", 32'(datao), 32'd0);
        clear_ovf();
        check("t3_ovf_cleared", 32'(overflow), 32'd0);

        // push and pop in the same cycle while full
        for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        check("t4_count", 32'(count), 32'd8);
        check("t4_overflow", 32'(overflow), 32'd0);
        check_state("t4");
        read_n(DEPTH);
        check_state("t4_drained");

        // timeout after 4 data bits, then recovery
        err_exp++;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'(i), 1'b0);
        repeat (TIMEOUT + 50) @(posedge clk); #1;
        check("t5_timeout_error_seen", 32'(err_exp), 32'd0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        check("t5_datao", 32'(datao), 32'hF0);
        check_state("t5");
        read_n(1);

        // asynchronous reset mid-frame with 3 entries queued
        send_frame(8'h21, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0);
        send_frame(8'h23, 1'b0, 1'b0, 1'b0);
        check("t6_count_before", 32'(count), 32'd3);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        check("t6_async_count", 32'(count), 32'd0);
        check("t6_async_empty", 32'(empty), 32'd1);
        check("t6_async_datao", 32'(datao), 32'd0);
        check("t6_async_interrupt", 32'(interrupt), 32'd0);
        ref_q.delete();
        ref_ovf = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check("t6_count_after", 32'(count), 32'd1);
        check("t6_datao_after", 32'(datao), 32'h5A);

        // randomised traffic against the queue model
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
            else if (r == 6) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
            else if (r == 7) send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0);
            else if (r == 8) read_n($urandom_range(1, 4));
            else             clear_ovf();
            check_state("rand");
        end
        read_n(DEPTH + 1);
        check_state("final");
        check("all_errors_seen", 32'(err_exp), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
